// File: rtl/rope_pkg.sv
// Shared definitions for the rope simulation blocks.
//   COORD_W / FRAC_BITS : Q16.16 signed coordinate format
//   sweep_state_e       : constraint_sweep controller states
//   point_t             : (x, y) coordinate pair shared with enforce_constraint and the integrator
package rope_pkg;

   localparam int unsigned COORD_W   = 32;
   localparam int unsigned FRAC_BITS = 16;

   typedef enum logic [2:0] {
      StIdle,
      StRd0,
      StRd1,
      StRd2,
      StFill,
      StEval,
      StDone
   } sweep_state_e;

   typedef struct packed {
      logic signed [COORD_W-1:0] x;
      logic signed [COORD_W-1:0] y;
   } point_t;

   // The controller is busy from the first read through the final evaluation.
   function automatic logic state_is_busy(input sweep_state_e st);
      return (st != StIdle) && (st != StDone);
   endfunction

endpackage

// File: rtl/point_window.sv
// Three-stage up/cur/down window over consecutive chain points.
//   clk, rst_n          : clock, asynchronous active-low reset (all stages clear to 0)
//   load_up             : up   <- read data
//   load_cur            : cur  <- read data
//   load_down           : down <- read data, or down <- cur when mirror is set
//   shift               : up <- enforced point, cur <- down (down holds)
//   rd_x, rd_y          : RAM read data
//   enf_x, enf_y        : enforced point from the constraint unit
//   up_*, cur_*, down_* : window contents
module point_window #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_up,
   input  logic              load_cur,
   input  logic              load_down,
   input  logic              mirror,
   input  logic              shift,
   input  logic [DATA_W-1:0] rd_x,
   input  logic [DATA_W-1:0] rd_y,
   input  logic [DATA_W-1:0] enf_x,
   input  logic [DATA_W-1:0] enf_y,
   output logic [DATA_W-1:0] up_x,
   output logic [DATA_W-1:0] up_y,
   output logic [DATA_W-1:0] cur_x,
   output logic [DATA_W-1:0] cur_y,
   output logic [DATA_W-1:0] down_x,
   output logic [DATA_W-1:0] down_y
);

   logic [DATA_W-1:0] up_x_q, up_y_q, cur_x_q, cur_y_q, down_x_q, down_y_q;
   logic [DATA_W-1:0] up_x_d, up_y_d, cur_x_d, cur_y_d, down_x_d, down_y_d;

   always_comb begin
      up_x_d   = up_x_q;
      up_y_d   = up_y_q;
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      down_x_d = down_x_q;
      down_y_d = down_y_q;

      // The enforced result becomes the new upper neighbour: Gauss-Seidel order.
      if (load_up) begin
         up_x_d = rd_x;
         up_y_d = rd_y;
      end else if (shift) begin
         up_x_d = enf_x;
         up_y_d = enf_y;
      end

      if (load_cur) begin
         cur_x_d = rd_x;
         cur_y_d = rd_y;
      end else if (shift) begin
         cur_x_d = down_x_q;
         cur_y_d = down_y_q;
      end

      // The last point has no lower neighbour; present it as its own.
      if (load_down) begin
         if (mirror) begin
            down_x_d = cur_x_q;
            down_y_d = cur_y_q;
         end else begin
            down_x_d = rd_x;
            down_y_d = rd_y;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_x_q   <= '0;
         up_y_q   <= '0;
         cur_x_q  <= '0;
         cur_y_q  <= '0;
         down_x_q <= '0;
         down_y_q <= '0;
      end else begin
         up_x_q   <= up_x_d;
         up_y_q   <= up_y_d;
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         down_x_q <= down_x_d;
         down_y_q <= down_y_d;
      end
   end

   assign up_x   = up_x_q;
   assign up_y   = up_y_q;
   assign cur_x  = cur_x_q;
   assign cur_y  = cur_y_q;
   assign down_x = down_x_q;
   assign down_y = down_y_q;

endmodule

// File: rtl/constraint_sweep.sv
// Sweeps the rope length constraint down the chain of points held in a dual-port RAM.
// Point 0 is the anchor and is never written; every other point is rewritten with the
// constraint unit's result, seeing the already-corrected upper neighbour.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   start                           : begin a run (only honoured while idle)
//   busy, done                      : run in progress / one-cycle completion pulse
//   mem_rd_en, mem_rd_addr          : read port request
//   mem_rd_x, mem_rd_y              : read data, valid the cycle after mem_rd_en
//   mem_wr_en, mem_wr_addr          : write port request
//   mem_wr_x, mem_wr_y              : write data
//   up_*_pos, *_pos, down_*_pos     : window presented to the constraint unit
//   is_last                         : evaluating the final point of the chain
//   x_enforced, y_enforced          : combinational constraint result
module constraint_sweep
   import rope_pkg::*;
#(
   parameter int unsigned N_POINTS   = 16,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ITERATIONS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_x,
   input  logic [DATA_W-1:0] mem_rd_y,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_x,
   output logic [DATA_W-1:0] mem_wr_y,
   output logic [DATA_W-1:0] up_x_pos,
   output logic [DATA_W-1:0] up_y_pos,
   output logic [DATA_W-1:0] x_pos,
   output logic [DATA_W-1:0] y_pos,
   output logic [DATA_W-1:0] down_x_pos,
   output logic [DATA_W-1:0] down_y_pos,
   output logic              is_last,
   input  logic [DATA_W-1:0] x_enforced,
   input  logic [DATA_W-1:0] y_enforced
);

   localparam int unsigned      S_W          = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
   localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(N_POINTS - 1);
   localparam logic [ADDR_W:0]   LAST_IDX_EXT = (ADDR_W + 1)'(N_POINTS - 1);
   localparam logic [S_W-1:0]    LAST_SWEEP   = S_W'(ITERATIONS - 1);

   sweep_state_e      state_q, state_d;
   logic [ADDR_W-1:0] i_q, i_d;
   logic [S_W-1:0]    s_q, s_d;

   logic [ADDR_W:0] i_plus2;
   logic            at_last;
   logic            rd_ahead;

   logic load_up, load_cur, load_down, mirror, shift;

   // One extra bit so i+2 cannot wrap when the chain fills the address space.
   assign i_plus2  = {1'b0, i_q} + (ADDR_W + 1)'(2);
   assign at_last  = (i_q == LAST_IDX);
   assign rd_ahead = (i_plus2 <= LAST_IDX_EXT);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         i_q     <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         s_q     <= s_d;
      end
   end

   // Next-state and counters
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      s_d     = s_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRd0;
               i_d     = ADDR_W'(1);
               s_d     = '0;
            end
         end
         StRd0:  state_d = StRd1;
         StRd1:  state_d = StRd2;
         StRd2:  state_d = StFill;
         StFill: state_d = StEval;
         StEval: begin
            if (!at_last) begin
               i_d     = i_q + ADDR_W'(1);
               state_d = StFill;
            end else if (s_q != LAST_SWEEP) begin
               s_d     = s_q + S_W'(1);
               i_d     = ADDR_W'(1);
               state_d = StRd0;
            end else begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs and window controls
   always_comb begin
      busy        = state_is_busy(state_q);
      done        = 1'b0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      mem_wr_en   = 1'b0;
      mem_wr_addr = '0;
      mem_wr_x    = '0;
      mem_wr_y    = '0;
      is_last     = 1'b0;
      load_up     = 1'b0;
      load_cur    = 1'b0;
      load_down   = 1'b0;
      mirror      = 1'b0;
      shift       = 1'b0;
      unique case (state_q)
         StRd0: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = ADDR_W'(0);
         end
         StRd1: begin
            load_up     = 1'b1;
            mem_rd_en   = 1'b1;
            mem_rd_addr = ADDR_W'(1);
         end
         StRd2: begin
            load_cur    = 1'b1;
            mem_rd_en   = 1'b1;
            mem_rd_addr = ADDR_W'(2);
         end
         StFill: begin
            load_down = 1'b1;
            mirror    = at_last;
         end
         StEval: begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = i_q;
            mem_wr_x    = x_enforced;
            mem_wr_y    = y_enforced;
            is_last     = at_last;
            shift       = 1'b1;
            // Read address i+2 never collides with write address i.
            if (rd_ahead) begin
               mem_rd_en   = 1'b1;
               mem_rd_addr = i_plus2[ADDR_W-1:0];
            end
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   point_window #(
      .DATA_W (DATA_W)
   ) u_window (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_up   (load_up),
      .load_cur  (load_cur),
      .load_down (load_down),
      .mirror    (mirror),
      .shift     (shift),
      .rd_x      (mem_rd_x),
      .rd_y      (mem_rd_y),
      .enf_x     (x_enforced),
      .enf_y     (y_enforced),
      .up_x      (up_x_pos),
      .up_y      (up_y_pos),
      .cur_x     (x_pos),
      .cur_y     (y_pos),
      .down_x    (down_x_pos),
      .down_y    (down_y_pos)
   );

endmodule
